branch_predict_unit: RTL and testbench
======================================

BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 Parameter IDX_W, default 4, table index width; the table SHALL hold 2^IDX_W entries.
REQ-002 Port clk, input, 1, sole clock; all state SHALL update on its rising edge.
REQ-003 Port reset, input, 1; reset is synchronous and active-high.
REQ-004 Port pc_f, input, 32, fetch-stage PC.
REQ-005 Port stall_d, input, 1, hold the F->D prediction register.
REQ-006 Port flush_d, input, 1, clear the F->D prediction register.
REQ-007 Port flush_e, input, 1, clear the D->E prediction register.
REQ-008 Port update_e, input, 1, a branch is resolved in EX this cycle.
REQ-009 Port pc_e, input, 32, PC of the resolved branch.
REQ-010 Port taken_e, input, 1, actual branch outcome.
REQ-011 Port target_e, input, 32, actual branch target.
REQ-012 Port predict_taken_f, output, 1, fetch-stage taken prediction.
REQ-013 Port next_pc_f, output, 32, predicted next fetch PC.
REQ-014 Port branchfound_d, output, 1, prediction bit aligned to ID.
REQ-015 Port branchfound_e, output, 1, prediction bit aligned to EX; the hazard unit compares it with the actual outcome.
REQ-016 Port resolved_cnt, output, 16, count of resolved branches.
REQ-017 Port mispredict_cnt, output, 16, count of mispredictions.

Function
REQ-018 Index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2]; each entry SHALL hold valid, tag, 32-bit target and a 2-bit counter.
REQ-019 Lookup SHALL be combinational: hit = valid AND tag match at index(pc_f); predict_taken_f = hit AND counter[1].
REQ-020 next_pc_f SHALL be the stored target when predict_taken_f = 1, else pc_f+4 with 32-bit wrap (0xFFFFFFFC -> 0x00000000).
REQ-021 F->D register: flush_d SHALL load 0; else if stall_d = 1 it SHALL hold; else it SHALL load predict_taken_f; flush_d takes priority over stall_d.
REQ-022 D->E register: flush_e SHALL load 0; otherwise it SHALL load branchfound_d every cycle.
REQ-023 Update on update_e = 1 with a hit at index(pc_e): counter SHALL increment if taken_e = 1, else decrement, saturating at 3 and 0; if taken_e = 1 the target SHALL be overwritten with target_e.
REQ-024 Update on update_e = 1 with a miss: if taken_e = 1, allocate valid = 1, tag(pc_e), target_e and counter = 2; if taken_e = 0, no table change.
REQ-025 A miss SHALL replace any entry at that index; there is no associativity.
REQ-026 Same-cycle lookup and update at the same index: the lookup SHALL see pre-update contents, with no bypass.
REQ-027 Table updates SHALL occur regardless of stall_d, flush_d and flush_e.
REQ-028 Misprediction = update_e AND (taken_e XOR branchfound_e).

Reset
REQ-029 On reset, all valid bits SHALL be 0, all counters 1, both pipeline registers 0, and both count outputs 0; tags and targets are don't-care.
REQ-030 Reset SHALL override a simultaneous update_e.
REQ-031 After reset deasserts, predict_taken_f SHALL be 0 and next_pc_f SHALL be pc_f+4.

Configuration
REQ-032 Macro BP_STATS_EN: when defined, resolved_cnt SHALL increment on each update_e and mispredict_cnt on each misprediction, both saturating at 0xFFFF.
REQ-033 When BP_STATS_EN is undefined, both count outputs SHALL be constant 0 and no counter logic SHALL be built.

Verification
REQ-034 Cold miss: after reset, pc_f = 0x00000040 -> predict_taken_f = 0 and next_pc_f = 0x00000044.
REQ-035 Allocate: update_e with pc_e = 0x40, taken_e = 1, target_e = 0x100; next cycle pc_f = 0x40 -> predict_taken_f = 1 and next_pc_f = 0x100.
REQ-036 Hysteresis: from counter 2, one not-taken update -> counter 1 and the prediction becomes not-taken; four taken updates -> counter saturates at 3, and one not-taken update still predicts taken.
REQ-037 Alias: entry for 0x40 exists, then taken update at pc_e = 0x440 (same index) -> 0x40 misses and 0x440 hits.
REQ-038 Pipeline: predict_taken_f = 1 with stall_d = 1 for 2 cycles -> branchfound_d holds; flush_d with stall_d set -> branchfound_d = 0; flush_e -> branchfound_e = 0 the next cycle.
REQ-039 Stats (BP_STATS_EN): 3 updates, one with taken_e != branchfound_e -> resolved_cnt = 3 and mispredict_cnt = 1; preload near 0xFFFF -> holds at 0xFFFF.

Source files
------------

// File: rtl/branch_predict_unit.sv
// Direct-mapped branch target buffer with 2-bit counters and F->D->E prediction pipeline.
// Latency: combinational lookup, one-cycle table update; optional stats counters under BP_STATS_EN.
// Backpressure: stall_d holds the F->D prediction bit; flush_d/flush_e clear; table updates never stall.
module branch_predict_unit #(
    parameter int IDX_W = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_f,
    input  logic        stall_d,
    input  logic        flush_d,
    input  logic        flush_e,
    input  logic        update_e,
    input  logic [31:0] pc_e,
    input  logic        taken_e,
    input  logic [31:0] target_e,
    output logic        predict_taken_f,
    output logic [31:0] next_pc_f,
    output logic        branchfound_d,
    output logic        branchfound_e,
    output logic [15:0] resolved_cnt,
    output logic [15:0] mispredict_cnt
);

    localparam int N     = 1 << IDX_W;
    localparam int TAG_W = 30 - IDX_W;

    logic             r_valid  [N];
    logic [TAG_W-1:0] r_tag    [N];
    logic [31:0]      r_target [N];
    logic [1:0]       r_ctr    [N];
    logic             r_bf_d;
    logic             r_bf_e;

    logic [IDX_W-1:0] w_idx_f;
    logic [IDX_W-1:0] w_idx_e;
    logic [TAG_W-1:0] w_tag_f;
    logic [TAG_W-1:0] w_tag_e;
    logic             w_hit_f;
    logic             w_hit_e;
    logic             w_unused_bits;

    assign w_idx_f = pc_f[IDX_W+1:2];
    assign w_tag_f = pc_f[31:IDX_W+2];
    assign w_idx_e = pc_e[IDX_W+1:2];
    assign w_tag_e = pc_e[31:IDX_W+2];
    assign w_unused_bits = ^{pc_f[1:0], pc_e[1:0]};

    // Lookup reads the registered table, so a same-cycle update is not visible here.
    assign w_hit_f         = r_valid[w_idx_f] && (r_tag[w_idx_f] == w_tag_f);
    assign w_hit_e         = r_valid[w_idx_e] && (r_tag[w_idx_e] == w_tag_e);
    assign predict_taken_f = w_hit_f && r_ctr[w_idx_f][1];
    assign next_pc_f       = predict_taken_f ? r_target[w_idx_f] : pc_f + 32'd4;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                r_valid[i] <= 1'b0;
                r_ctr[i]   <= 2'd1;
            end
        end else if (update_e) begin
            if (w_hit_e) begin
                if (taken_e && r_ctr[w_idx_e] != 2'd3)
                    r_ctr[w_idx_e] <= r_ctr[w_idx_e] + 2'd1;
                else if (!taken_e && r_ctr[w_idx_e] != 2'd0)
                    r_ctr[w_idx_e] <= r_ctr[w_idx_e] - 2'd1;
            end else if (taken_e) begin
                r_valid[w_idx_e] <= 1'b1;
                r_ctr[w_idx_e]   <= 2'd2;
            end
        end
    end

    // Tag and target need no reset; a taken update either rewrites the same tag or allocates.
    always_ff @(posedge clk) begin
        if (!reset && update_e && taken_e) begin
            r_tag[w_idx_e]    <= w_tag_e;
            r_target[w_idx_e] <= target_e;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bf_d <= 1'b0;
            r_bf_e <= 1'b0;
        end else begin
            if (flush_d)
                r_bf_d <= 1'b0;
            else if (!stall_d)
                r_bf_d <= predict_taken_f;
            r_bf_e <= flush_e ? 1'b0 : r_bf_d;
        end
    end

    assign branchfound_d = r_bf_d;
    assign branchfound_e = r_bf_e;

`ifdef BP_STATS_EN
    logic [15:0] r_resolved_cnt;
    logic [15:0] r_mispredict_cnt;
    logic        w_mispredict;

    assign w_mispredict = update_e && (taken_e ^ r_bf_e);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_resolved_cnt   <= 16'd0;
            r_mispredict_cnt <= 16'd0;
        end else begin
            if (update_e && r_resolved_cnt != 16'hFFFF)
                r_resolved_cnt <= r_resolved_cnt + 16'd1;
            if (w_mispredict && r_mispredict_cnt != 16'hFFFF)
                r_mispredict_cnt <= r_mispredict_cnt + 16'd1;
        end
    end

    assign resolved_cnt   = r_resolved_cnt;
    assign mispredict_cnt = r_mispredict_cnt;
`else
    assign resolved_cnt   = 16'd0;
    assign mispredict_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed-vector bench for branch_predict_unit; stats checks follow BP_STATS_EN.
module tb_branch_predict_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_f;
    logic        stall_d, flush_d, flush_e;
    logic        update_e;
    logic [31:0] pc_e;
    logic        taken_e;
    logic [31:0] target_e;
    logic        predict_taken_f;
    logic [31:0] next_pc_f;
    logic        branchfound_d, branchfound_e;
    logic [15:0] resolved_cnt, mispredict_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    branch_predict_unit #(.IDX_W(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .pc_f           (pc_f),
        .stall_d        (stall_d),
        .flush_d        (flush_d),
        .flush_e        (flush_e),
        .update_e       (update_e),
        .pc_e           (pc_e),
        .taken_e        (taken_e),
        .target_e       (target_e),
        .predict_taken_f(predict_taken_f),
        .next_pc_f      (next_pc_f),
        .branchfound_d  (branchfound_d),
        .branchfound_e  (branchfound_e),
        .resolved_cnt   (resolved_cnt),
        .mispredict_cnt (mispredict_cnt)
    );

    typedef struct {
        logic [31:0] pc_f;
        logic        upd;
        logic [31:0] pc_e;
        logic        tkn;
        logic [31:0] tgt;
        logic        exp_pt;
        logic [31:0] exp_npc;
        logic        exp_bfd;
        logic        exp_bfe;
    } vec_t;

    vec_t vt [19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            pc_f          upd   pc_e          tkn   tgt           pt    npc           bfd   bfe
        vt[0]  = '{32'h00000040, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h00000044, 1'b0, 1'b0};
        vt[1]  = '{32'h00000040, 1'b1, 32'h00000040, 1'b1, 32'h00000100, 1'b0, 32'h00000044, 1'b0, 1'b0};
        vt[2]  = '{32'h00000040, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h00000100, 1'b0, 1'b0};
        vt[3]  = '{32'h00000040, 1'b1, 32'h00000040, 1'b0, 32'h0,        1'b1, 32'h00000100, 1'b1, 1'b0};
        vt[4]  = '{32'h00000040, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h00000044, 1'b1, 1'b1};
        vt[5]  = '{32'h00000040, 1'b1, 32'h00000040, 1'b1, 32'h00000100, 1'b0, 32'h00000044, 1'b0, 1'b1};
        vt[6]  = '{32'h00000040, 1'b1, 32'h00000040, 1'b1, 32'h00000100, 1'b1, 32'h00000100, 1'b0, 1'b0};
        vt[7]  = '{32'h00000040, 1'b1, 32'h00000040, 1'b1, 32'h00000100, 1'b1, 32'h00000100, 1'b1, 1'b0};
        vt[8]  = '{32'h00000040, 1'b1, 32'h00000040, 1'b1, 32'h00000100, 1'b1, 32'h00000100, 1'b1, 1'b1};
        vt[9]  = '{32'h00000040, 1'b1, 32'h00000040, 1'b0, 32'h0,        1'b1, 32'h00000100, 1'b1, 1'b1};
        vt[10] = '{32'h00000040, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h00000100, 1'b1, 1'b1};
        vt[11] = '{32'h00000040, 1'b1, 32'h00000040, 1'b1, 32'h00000200, 1'b1, 32'h00000100, 1'b1, 1'b1};
        vt[12] = '{32'h00000040, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h00000200, 1'b1, 1'b1};
        vt[13] = '{32'h00000440, 1'b1, 32'h00000440, 1'b1, 32'h00000300, 1'b0, 32'h00000444, 1'b1, 1'b1};
        vt[14] = '{32'h00000040, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h00000044, 1'b0, 1'b1};
        vt[15] = '{32'h00000440, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h00000300, 1'b0, 1'b0};
        vt[16] = '{32'h00000080, 1'b1, 32'h00000080, 1'b0, 32'h0,        1'b0, 32'h00000084, 1'b1, 1'b0};
        vt[17] = '{32'h00000440, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h00000300, 1'b0, 1'b1};
        vt[18] = '{32'hFFFFFFFC, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h00000000, 1'b1, 1'b0};

        // Reset with a concurrent taken update that must be ignored.
        reset = 1'b1; pc_f = 32'h40; stall_d = 1'b0; flush_d = 1'b0; flush_e = 1'b0;
        update_e = 1'b1; pc_e = 32'h40; taken_e = 1'b1; target_e = 32'h100;
        tick(); tick();
        reset = 1'b0; update_e = 1'b0; taken_e = 1'b0;
        chk("rst_bf_d", {31'd0, branchfound_d}, 32'd0);
        chk("rst_bf_e", {31'd0, branchfound_e}, 32'd0);
        chk("rst_resolved", {16'd0, resolved_cnt}, 32'd0);
        chk("rst_mispred", {16'd0, mispredict_cnt}, 32'd0);

        for (int k = 0; k < 19; k++) begin
            pc_f = vt[k].pc_f; update_e = vt[k].upd; pc_e = vt[k].pc_e;
            taken_e = vt[k].tkn; target_e = vt[k].tgt;
            #3;
            chk($sformatf("v%0d_pt", k),  {31'd0, predict_taken_f}, {31'd0, vt[k].exp_pt});
            chk($sformatf("v%0d_npc", k), next_pc_f, vt[k].exp_npc);
            chk($sformatf("v%0d_bfd", k), {31'd0, branchfound_d}, {31'd0, vt[k].exp_bfd});
            chk($sformatf("v%0d_bfe", k), {31'd0, branchfound_e}, {31'd0, vt[k].exp_bfe});
            tick();
        end
        update_e = 1'b0; taken_e = 1'b0;

        // Stall holds, flush_d beats stall_d, flush_e clears EX stage.
        pc_f = 32'h440;
        tick();
        chk("pipe_load", {31'd0, branchfound_d}, 32'd1);
        stall_d = 1'b1; pc_f = 32'h40;
        tick();
        chk("stall_hold1", {31'd0, branchfound_d}, 32'd1);
        tick();
        chk("stall_hold2", {31'd0, branchfound_d}, 32'd1);
        flush_d = 1'b1;
        tick();
        chk("flush_d_over_stall", {31'd0, branchfound_d}, 32'd0);
        flush_d = 1'b0; stall_d = 1'b0; pc_f = 32'h440;
        tick();
        chk("reload_bf_d", {31'd0, branchfound_d}, 32'd1);
        flush_e = 1'b1;
        tick();
        chk("flush_e", {31'd0, branchfound_e}, 32'd0);
        flush_e = 1'b0;
        tick();
        chk("after_flush_e", {31'd0, branchfound_e}, 32'd1);

        // Reset clears previously allocated entries.
        reset = 1'b1;
        tick();
        reset = 1'b0; pc_f = 32'h440;
        #3;
        chk("post_rst_pt", {31'd0, predict_taken_f}, 32'd0);
        chk("post_rst_npc", next_pc_f, 32'h444);
        tick();
        pc_f = 32'h0C;

`ifdef BP_STATS_EN
        update_e = 1'b1; pc_e = 32'h80; taken_e = 1'b0;
        tick(); tick();
        taken_e = 1'b1; target_e = 32'h500;
        tick();
        update_e = 1'b0;
        tick();
        chk("resolved_3", {16'd0, resolved_cnt}, 32'd3);
        chk("mispred_1", {16'd0, mispredict_cnt}, 32'd1);
        update_e = 1'b1; taken_e = 1'b1;
        for (int k = 0; k < 65540; k++) tick();
        update_e = 1'b0;
        tick();
        chk("resolved_sat", {16'd0, resolved_cnt}, 32'hFFFF);
        chk("mispred_sat", {16'd0, mispredict_cnt}, 32'hFFFF);
`else
        update_e = 1'b1; pc_e = 32'h80; taken_e = 1'b1; target_e = 32'h500;
        tick(); tick(); tick();
        update_e = 1'b0;
        tick();
        chk("resolved_off", {16'd0, resolved_cnt}, 32'd0);
        chk("mispred_off", {16'd0, mispredict_cnt}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
